fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Control block for the register-fetch stage of the pipelined ARM core. It tracks the destination-register tags of the instructions in EX and MEM, and drives the 2-bit select of the two 64-bit 4:1 operand muxes (A and B) that feed the ALU operand registers. It detects load-use hazards and requests a one-cycle stall with a bubble into EX. It also flags when condition codes must come straight from the ALU instead of the flag register.

Parameters:
REG_BITS, 5, width of a register index
ZERO_REG, 31, index of XZR; never forwarded, never a hazard source
CNT_BITS, 16, width of the saturating stall counter

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
id_valid  input  1  ID holds a real instruction (0 = flushed/bubble)
id_rn  input  REG_BITS  operand-A read address
id_rm  input  REG_BITS  operand-B read address (already Reg2Loc-selected)
id_uses_rn  input  1  instruction actually reads Rn
id_uses_rm  input  1  instruction actually reads Rm
id_rd  input  REG_BITS  destination register
id_reg_write  input  1  instruction writes Rd
id_mem_read  input  1  instruction is a load
id_set_flags  input  1  instruction updates NZCV
fwd_a  output  2  select for operand-A mux
fwd_b  output  2  select for operand-B mux
stall  output  1  hold PC and IF/ID, insert bubble into EX
flag_fwd  output  1  1 = use live ALU flags, 0 = use flag register
stall_cnt  output  CNT_BITS  number of stall cycles since reset, saturating

Behaviour:
- State registers: ex_rd, ex_wr, ex_ld, ex_sf (EX tag); mem_rd, mem_wr (MEM tag); stall_cnt.
- Reset, checked at the clock edge: all tag bits and rds = 0, stall_cnt = 0.
  - Outputs after reset: fwd_a = fwd_b = 2'b00, stall = 0, flag_fwd = 0.
- Mux select encoding:
  - 00 = register file
  - 01 = EX result (ALU output)
  - 10 = MEM result (ALU pass-through or load data)
  - 11 = reserved, never driven. No WB forwarding is needed because the regfile writes before read.
- fwd_a, fwd_b, stall and flag_fwd are combinational from the ID inputs and the current tags. They are valid in the same cycle, with zero latency.
- Matches:
  - ex_hit(r): ex_wr & (ex_rd == r) & (r != ZERO_REG)
  - mem_hit(r): same form using mem_wr and mem_rd
- fwd_a:
  - 01 if id_uses_rn & ex_hit(id_rn) & !ex_ld
  - else 10 if id_uses_rn & mem_hit(id_rn)
  - else 00
  - EX has priority over MEM because it is the newest value.
- fwd_b: the same rule using id_rm and id_uses_rm.
- stall = id_valid & ex_ld & ((id_uses_rn & ex_hit(id_rn)) | (id_uses_rm & ex_hit(id_rm))).
  - A load match in EX never yields 01; the select falls through to the MEM or regfile rule.
- flag_fwd = ex_sf.
- Rising-edge update when not in reset:
  - stall = 1: the EX tag becomes a bubble (ex_wr = ex_ld = ex_sf = 0, ex_rd = 0). The MEM tag takes the old EX tag. stall_cnt increments unless it is all-ones.
  - stall = 0: the EX tag takes the ID fields ANDed with id_valid. The MEM tag takes the old EX tag.
- Next cycle after a stall: the load sits in MEM, so the same ID instruction sees 10 and stall = 0. A load-use pair therefore costs exactly 1 stall cycle.
- Simultaneous EX and MEM hits on the same register: EX wins. If the EX hit is a load, the result is a stall, and the select is 10 for that cycle (from the older MEM match), which is harmless.
- id_valid = 0: no stall and no tag entry, but fwd outputs are still computed (don't-care downstream).
- Reset asserted mid-stall: all tags clear and stall deasserts on the following cycle. There is no leftover bubble state.
- stall_cnt saturates at 2^CNT_BITS-1 and never wraps.

Test Plan:
1. EX-to-operand forwarding. Cycle 0: ID ADD X3 (rd=3, wr=1). Cycle 1: ID rn=3, rm=4, both used. Required: fwd_a=01, fwd_b=00, stall=0.
2. MEM forwarding and priority.
   - ADD X5, then an unrelated instruction, then an instruction reading rn=5: fwd_a=10.
   - ADD X5, then SUB X5, then read of X5: fwd_a=01 (EX wins).
3. Load-use stall. LDUR X2 followed by ADD reading rm=2.
   - First cycle: stall=1, fwd_b=00, stall_cnt goes 0→1.
   - Next cycle, same ID inputs: stall=0, fwd_b=10.
   - Same sequence with id_uses_rm=0: stall=0 throughout.
4. XZR and invalid instructions.
   - Write to rd=31, then read of rn=31: fwd_a=00.
   - id_valid=0 with wr=1, rd=7, then read of X7: fwd=00, stall=0.
5. Flags and reset. SUBS (set_flags=1) then B.cond: flag_fwd=1 in the B.cond's ID cycle. Assert reset during a stall cycle: next cycle all outputs 0 and stall_cnt=0.
6. Counter saturation. With CNT_BITS=2, force 5 consecutive load-use stalls: stall_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Purpose  : Operand forwarding selects, load-use stall and flag bypass for
//            the register-fetch stage, with a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int REG_BITS = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rn,
    input  logic [REG_BITS-1:0] id_rm,
    input  logic                id_uses_rn,
    input  logic                id_uses_rm,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_set_flags,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                stall,
    output logic                flag_fwd,
    output logic [CNT_BITS-1:0] stall_cnt
);

    localparam logic [REG_BITS-1:0] c_zero    = REG_BITS'(ZERO_REG);
    localparam logic [1:0]          c_sel_rf  = 2'b00;
    localparam logic [1:0]          c_sel_ex  = 2'b01;
    localparam logic [1:0]          c_sel_mem = 2'b10;

    logic [REG_BITS-1:0] ex_rd_q,  ex_rd_d;
    logic                ex_wr_q,  ex_wr_d;
    logic                ex_ld_q,  ex_ld_d;
    logic                ex_sf_q,  ex_sf_d;
    logic [REG_BITS-1:0] mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

    logic w_ex_hit_a, w_ex_hit_b, w_mem_hit_a, w_mem_hit_b;

    always_comb begin
        w_ex_hit_a  = ex_wr_q  && (ex_rd_q  == id_rn) && (id_rn != c_zero);
        w_ex_hit_b  = ex_wr_q  && (ex_rd_q  == id_rm) && (id_rm != c_zero);
        w_mem_hit_a = mem_wr_q && (mem_rd_q == id_rn) && (id_rn != c_zero);
        w_mem_hit_b = mem_wr_q && (mem_rd_q == id_rm) && (id_rm != c_zero);
    end

    // A load in EX has no result yet, so its match falls through to MEM/regfile.
    always_comb begin
        fwd_a = c_sel_rf;
        if (id_uses_rn && w_ex_hit_a && !ex_ld_q) begin
            fwd_a = c_sel_ex;
        end else if (id_uses_rn && w_mem_hit_a) begin
            fwd_a = c_sel_mem;
        end

        fwd_b = c_sel_rf;
        if (id_uses_rm && w_ex_hit_b && !ex_ld_q) begin
            fwd_b = c_sel_ex;
        end else if (id_uses_rm && w_mem_hit_b) begin
            fwd_b = c_sel_mem;
        end

        stall    = id_valid && ex_ld_q &&
                   ((id_uses_rn && w_ex_hit_a) || (id_uses_rm && w_ex_hit_b));
        flag_fwd = ex_sf_q;
    end

    always_comb begin
        mem_rd_d    = ex_rd_q;
        mem_wr_d    = ex_wr_q;
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            ex_rd_d = '0;
            ex_wr_d = 1'b0;
            ex_ld_d = 1'b0;
            ex_sf_d = 1'b0;
            if (!(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
            end
        end else begin
            ex_rd_d = id_valid ? id_rd : '0;
            ex_wr_d = id_valid && id_reg_write;
            ex_ld_d = id_valid && id_mem_read;
            ex_sf_d = id_valid && id_set_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rd_q     <= '0;
            ex_wr_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            ex_sf_q     <= 1'b0;
            mem_rd_q    <= '0;
            mem_wr_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_rd_q     <= ex_rd_d;
            ex_wr_q     <= ex_wr_d;
            ex_ld_q     <= ex_ld_d;
            ex_sf_q     <= ex_sf_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Purpose  : Directed vector bench for fwd_hazard_unit, one row per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn, id_rm, id_rd;
    logic       id_uses_rn, id_uses_rm, id_reg_write, id_mem_read, id_set_flags;
    logic [1:0] fwd_a, fwd_b;
    logic       stall, flag_fwd;
    logic [15:0] stall_cnt;
    logic [1:0] s_fwd_a, s_fwd_b;
    logic       s_stall, s_flag_fwd;
    logic [1:0] s_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_set_flags(id_set_flags), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
        .flag_fwd(flag_fwd), .stall_cnt(stall_cnt)
    );

    fwd_hazard_unit #(.CNT_BITS(2)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_set_flags(id_set_flags), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall(s_stall),
        .flag_fwd(s_flag_fwd), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic        rst, chk, v;
        logic [4:0]  rn, rm;
        logic        urn, urm;
        logic [4:0]  rd;
        logic        wr, ld, sf;
        logic [1:0]  ea, eb;
        logic        est, eff;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int rst, int chk, int v, int rn, int rm, int urn, int urm,
                                int rd, int wr, int ld, int sf,
                                int ea, int eb, int est, int eff, int ecnt);
        vec_t r;
        r.rst = rst[0]; r.chk = chk[0]; r.v = v[0];
        r.rn = rn[4:0]; r.rm = rm[4:0]; r.urn = urn[0]; r.urm = urm[0];
        r.rd = rd[4:0]; r.wr = wr[0]; r.ld = ld[0]; r.sf = sf[0];
        r.ea = ea[1:0]; r.eb = eb[1:0]; r.est = est[0]; r.eff = eff[0];
        r.ecnt = ecnt[15:0];
        return r;
    endfunction

    task automatic drive(input logic rst, input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic urn, input logic urm, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic sf);
        reset = rst; id_valid = v; id_rn = rn; id_rm = rm;
        id_uses_rn = urn; id_uses_rm = urm; id_rd = rd;
        id_reg_write = wr; id_mem_read = ld; id_set_flags = sf;
    endtask

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        //            rst chk v  rn rm urn urm rd wr ld sf  ea eb st ff cnt
        vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0));
        // EX forwarding
        vecs.push_back(mk(0, 1, 1,  1, 2, 1, 1,  3, 1, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1,  3, 4, 1, 1,  0, 0, 0, 0,  1, 0, 0, 0, 0));
        // MEM forwarding, then EX-over-MEM priority
        vecs.push_back(mk(0, 1, 1,  0, 0, 0, 0,  5, 1, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1,  1, 2, 1, 1,  6, 1, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1,  5, 6, 1, 1,  0, 0, 0, 0,  2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1,  0, 0, 0, 0,  5, 1, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1,  5, 0, 1, 0,  5, 1, 0, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1,  5, 5, 1, 1,  0, 0, 0, 0,  1, 1, 0, 0, 0));
        // Load-use: one stall, then MEM forward
        vecs.push_back(mk(0, 1, 1,  9, 0, 1, 0,  2, 1, 1, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1,  1, 2, 1, 1,  8, 1, 0, 0,  0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1,  1, 2, 1, 1,  8, 1, 0, 0,  0, 2, 0, 0, 1));
        // Load followed by an instruction that does not read Rm
        vecs.push_back(mk(0, 1, 1,  9, 0, 1, 0,  2, 1, 1, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1,  1, 2, 1, 0,  8, 1, 0, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1,  1, 2, 1, 0,  8, 1, 0, 0,  0, 0, 0, 0, 1));
        // XZR and invalid instructions
        vecs.push_back(mk(0, 1, 1,  0, 0, 0, 0, 31, 1, 0, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 31,31, 1, 1,  0, 0, 0, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 31,31, 1, 1,  7, 1, 0, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1,  7, 7, 1, 1,  0, 0, 0, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1,  0, 0, 0, 0,  4, 1, 1, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0,  4, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1,  4, 0, 1, 0,  0, 0, 0, 0,  2, 0, 0, 0, 1));
        // Flag bypass
        vecs.push_back(mk(0, 1, 1,  0, 0, 0, 0,  1, 1, 0, 1,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1));
        // Load in EX and ALU op in MEM on the same register
        vecs.push_back(mk(0, 1, 1,  0, 0, 0, 0,  6, 1, 0, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1,  0, 0, 0, 0,  6, 1, 1, 0,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1,  6, 0, 1, 0,  0, 0, 0, 0,  2, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1,  6, 0, 1, 0,  0, 0, 0, 0,  2, 0, 0, 0, 2));
        // Reset during a stall cycle
        vecs.push_back(mk(0, 1, 1,  0, 0, 0, 0,  2, 1, 1, 0,  0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 1,  0, 2, 0, 1,  0, 0, 0, 0,  0, 0, 1, 0, 2));
        vecs.push_back(mk(0, 1, 1,  0, 2, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].v, vecs[i].rn, vecs[i].rm, vecs[i].urn, vecs[i].urm,
                  vecs[i].rd, vecs[i].wr, vecs[i].ld, vecs[i].sf);
            #1;
            if (vecs[i].chk) begin
                check("fwd_a",     i, {14'd0, fwd_a},  {14'd0, vecs[i].ea});
                check("fwd_b",     i, {14'd0, fwd_b},  {14'd0, vecs[i].eb});
                check("stall",     i, {15'd0, stall},  {15'd0, vecs[i].est});
                check("flag_fwd",  i, {15'd0, flag_fwd}, {15'd0, vecs[i].eff});
                check("stall_cnt", i, stall_cnt,       vecs[i].ecnt);
            end
        end

        // Saturation: five load-use pairs, wide counter counts on, 2-bit one sticks at 3
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(0, 1, 0, 0, 0, 0, 2, 1, 1, 0);
            @(negedge clk);
            drive(0, 1, 0, 2, 0, 1, 8, 1, 0, 0);
            #1;
            check("sat_stall", k, {15'd0, s_stall}, 16'd1);
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            check("sat_cnt",  k, {14'd0, s_stall_cnt}, (k < 3) ? 16'(k + 1) : 16'd3);
            check("wide_cnt", k, stall_cnt, 16'(k + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
